// File: rtl/mon_capture.sv
// Serial capture monitor: samples mon_in for nbits clocks, packs LSB-first words into a FIFO.
// Optional per-word cycle timestamp when MON_CAPTURE_TIMESTAMP_EN is defined.
module mon_capture #(
  parameter int ID    = 1,
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mon_in,
  input  logic                       arm,
  input  logic [15:0]                nbits,
  output logic                       busy,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_last,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       ovf,
  input  logic                       clr_ovf
`ifdef MON_CAPTURE_TIMESTAMP_EN
  ,
  output logic [31:0]                rd_ts
`endif
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ID < 0) begin : g_bad_cfg
    $error("mon_capture: DEPTH must be a power of two >= 2 and ID non-negative");
  end

  typedef enum logic {S_IDLE, S_CAPTURE} state_t;

  state_t            state, state_nxt;
  logic [15:0]       remaining;
  logic [BW-1:0]     bit_idx;
  logic [WIDTH-1:0]  shreg;
  logic [WIDTH-1:0]  cur_word;
  logic              accept, sample, push, push_last;

  logic [WIDTH-1:0]  mem      [DEPTH];
  logic              last_mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic              full, pop, wr_en, drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (arm && nbits != 16'd0) state_nxt = S_CAPTURE;
      S_CAPTURE: if (remaining == 16'd1)    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == S_CAPTURE);
    accept = (state == S_IDLE) && arm && (nbits != 16'd0);
    sample = (state == S_CAPTURE);
  end

  // Word under construction including the bit sampled at this edge.
  always_comb begin
    cur_word          = shreg;
    cur_word[bit_idx] = mon_in;
  end

  assign push_last = (remaining == 16'd1);
  assign push      = sample && ((bit_idx == BW'(WIDTH - 1)) || push_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
    end else if (accept) begin
      remaining <= nbits;
      bit_idx   <= '0;
      shreg     <= '0;
    end else if (sample) begin
      remaining <= remaining - 16'd1;
      if (push) begin
        bit_idx <= '0;
        shreg   <= '0;
      end else begin
        bit_idx <= bit_idx + BW'(1);
        shreg   <= cur_word;
      end
    end
  end

  assign rd_valid = (level != '0);
  assign full     = (level == LW'(DEPTH));
  assign pop      = rd_valid && rd_ready;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign wr_en    = push && (!full || pop);
  assign drop     = push && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ovf   <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (pop)   rptr <= rptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr]      <= cur_word;
      last_mem[wptr] <= push_last;
    end
  end

  assign rd_data = rd_valid ? mem[rptr] : '0;
  assign rd_last = rd_valid ? last_mem[rptr] : 1'b0;

`ifdef MON_CAPTURE_TIMESTAMP_EN
  logic [31:0] cyc, ts_lat, word_ts;
  logic [31:0] ts_mem [DEPTH];

  // Timestamp is the counter value seen at the edge sampling bit 0 of the word.
  assign word_ts = (bit_idx == '0) ? cyc : ts_lat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc    <= '0;
      ts_lat <= '0;
    end else begin
      cyc <= cyc + 32'd1;
      if (sample && bit_idx == '0) ts_lat <= cyc;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ts_mem[wptr] <= word_ts;
  end

  assign rd_ts = rd_valid ? ts_mem[rptr] : '0;
`endif

endmodule

// File: tb/tb_mon_capture.sv
// Randomized and directed bench for mon_capture against a queue-based capture model.
module tb_mon_capture;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              mon_in = 1'b0;
  logic              arm = 1'b0;
  logic [15:0]       nbits = '0;
  logic              busy;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_last;
  logic [LW-1:0]     level;
  logic              ovf;
  logic              clr_ovf = 1'b0;
`ifdef MON_CAPTURE_TIMESTAMP_EN
  logic [31:0]       rd_ts;
`endif

  int tests  = 0;
  int failed = 0;

  mon_capture #(.ID(1), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mon_in(mon_in), .arm(arm), .nbits(nbits),
    .busy(busy), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .level(level), .ovf(ovf), .clr_ovf(clr_ovf)
`ifdef MON_CAPTURE_TIMESTAMP_EN
    , .rd_ts(rd_ts)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a capture is a stream of bits cut into WIDTH-bit words.
  bit              cap_active;
  int              bits_left;
  bit              cur_bits[$];
  longint unsigned word_ts;
  longint unsigned cyc;
  longint unsigned q_data[$];
  bit              q_last[$];
  longint unsigned q_ts[$];
  bit              m_ovf;

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    cap_active = 0; bits_left = 0; cur_bits.delete(); word_ts = 0; cyc = 0;
    q_data.delete(); q_last.delete(); q_ts.delete(); m_ovf = 0;
  endtask

  task automatic model_edge();
    bit do_pop, do_push, w_last, full;
    longint unsigned w;
    do_pop  = (q_data.size() > 0) && rd_ready;
    do_push = 0; w = 0; w_last = 0;
    if (cap_active) begin
      if (cur_bits.size() == 0) word_ts = cyc;
      cur_bits.push_back(mon_in);
      bits_left--;
      if (cur_bits.size() == WIDTH || bits_left == 0) begin
        for (int i = 0; i < cur_bits.size(); i++) w += longint'(cur_bits[i]) << i;
        w_last  = (bits_left == 0);
        do_push = 1;
        cur_bits.delete();
      end
      if (bits_left == 0) cap_active = 0;
    end else if (arm && nbits != 0) begin
      cap_active = 1;
      bits_left  = int'(nbits);
    end
    full = (q_data.size() == DEPTH);
    if (do_pop) begin
      void'(q_data.pop_front()); void'(q_last.pop_front()); void'(q_ts.pop_front());
    end
    if (clr_ovf) m_ovf = 0;
    if (do_push) begin
      if (full && !do_pop) m_ovf = 1;
      else begin
        q_data.push_back(w); q_last.push_back(w_last); q_ts.push_back(word_ts);
      end
    end
    cyc = (cyc + 1) & 64'hFFFF_FFFF;
  endtask

  task automatic check_outputs();
    bit v;
    v = (q_data.size() > 0);
    chk("busy", busy, cap_active);
    chk("rd_valid", rd_valid, v);
    chk("rd_data", rd_data, v ? q_data[0] : 0);
    chk("rd_last", rd_last, v ? q_last[0] : 0);
    chk("level", level, q_data.size());
    chk("ovf", ovf, m_ovf);
`ifdef MON_CAPTURE_TIMESTAMP_EN
    chk("rd_ts", rd_ts, v ? q_ts[0] : 0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    arm = 0; nbits = 0; mon_in = 0; clr_ovf = 0;
  endtask

  task automatic start(input int n);
    arm = 1; nbits = 16'(n);
    step();
    arm = 0;
  endtask

  int busy_cnt, max_lvl, words;
  longint unsigned pops[$];
  logic [7:0] pat;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1;
    model_reset();
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_valid", rd_valid, 0);
    chk("reset_data", rd_data, 0);
    chk("reset_level", level, 0);
    chk("reset_ovf", ovf, 0);

    // 8-bit capture of 1,0,1,1,0,0,1,0
    pat = 8'b0100_1101;
    rd_ready = 0;
    start(8);
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      mon_in = pat[i];
      step();
      if (busy) busy_cnt++;
    end
    idle_inputs();
    chk("t1_busy_cycles", busy_cnt, 8);
    chk("t1_data", rd_data, 32'h0000_004D);
    chk("t1_last", rd_last, 1);
    rd_ready = 1;
    step();

    // 40 ones with consumer always ready
    max_lvl = 0;
    pops.delete();
    mon_in = 1;
    start(40);
    for (int i = 0; i < 44; i++) begin
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (rd_valid && rd_ready) pops.push_back({31'd0, rd_last, rd_data});
      step();
    end
    idle_inputs();
    chk("t2_max_level", max_lvl, 1);
    chk("t2_words", pops.size(), 2);
    if (pops.size() == 2) begin
      chk("t2_word0", pops[0], 64'h0_FFFF_FFFF);
      chk("t2_word1", pops[1], 64'h1_0000_00FF);
    end

    // 10 words into a stalled FIFO
    rd_ready = 0;
    start(320);
    for (int i = 0; i < 320; i++) begin
      mon_in = 1'($urandom);
      step();
    end
    idle_inputs();
    chk("t3_level", level, DEPTH);
    chk("t3_ovf", ovf, 1);
    rd_ready = 1;
    repeat (8) step();
    rd_ready = 0;
    clr_ovf = 1;
    step();
    clr_ovf = 0;
    chk("t3_ovf_clr", ovf, 0);
    chk("t3_empty", level, 0);

    // Full FIFO with a pop on the push edge
    start(256);
    for (int i = 0; i < 256; i++) begin mon_in = 1'($urandom); step(); end
    chk("t4_fill", level, DEPTH);
    start(32);
    for (int i = 0; i < 31; i++) begin mon_in = 1'($urandom); step(); end
    rd_ready = 1;
    mon_in = 1;
    step();
    rd_ready = 0;
    idle_inputs();
    chk("t4_level", level, DEPTH);
    chk("t4_ovf", ovf, 0);
    rd_ready = 1;
    repeat (8) step();

    // nbits=0 is ignored; arm during capture is ignored
    start(0);
    repeat (3) step();
    chk("t5_busy0", busy, 0);
    chk("t5_valid0", rd_valid, 0);
    words = 0;
    start(16);
    for (int i = 0; i < 20; i++) begin
      mon_in = 1'($urandom);
      arm = (i == 5); nbits = 16'd16;
      if (rd_valid && rd_ready) words++;
      step();
    end
    idle_inputs();
    chk("t5_words", words, 1);

    // Asynchronous reset in the middle of a capture
    start(32);
    for (int i = 0; i < 10; i++) begin mon_in = 1; step(); end
    rst = 0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_valid", rd_valid, 0);
    chk("t6_data", rd_data, 0);
    chk("t6_level", level, 0);
    chk("t6_ovf", ovf, 0);
    model_reset();
    #2 rst = 1;
    idle_inputs();
    repeat (40) step();
    chk("t6_no_word", rd_valid, 0);
    repeat (5) step();
    start(8);
    for (int i = 0; i < 8; i++) begin mon_in = 1'($urandom); step(); end
    chk("t6_new_word", rd_valid, 1);
`ifdef MON_CAPTURE_TIMESTAMP_EN
    chk("t6_ts", rd_ts, 46);
`endif
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      arm      = ($urandom_range(0, 7) == 0);
      nbits    = 16'($urandom_range(0, 90));
      mon_in   = 1'($urandom);
      rd_ready = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      clr_ovf  = ($urandom_range(0, 60) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
